// File: rtl/seq_mult32.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult32
//  Description : Shift-add multiplier, one product bit per clock. Optional
//                two's-complement mode is compiled in with MULT_SIGNED_EN.
//  Revision    : 1.0
// ============================================================================
module seq_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef MULT_SIGNED_EN
    input  logic                 SGN,
`endif
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   P,
    output logic [WIDTH-1:0]     PLO
);

    localparam int c_CNTW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CNTW-1:0]    c_CNT_LOAD = c_CNTW'(WIDTH);
    localparam logic [c_CNTW-1:0]    c_CNT_ONE  = c_CNTW'(1);
    localparam logic [WIDTH-1:0]     c_ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0]   c_ONE_P    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_accHi;
    logic [c_CNTW-1:0]    r_count;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_negA;
    logic                 w_negB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prodMag;
    logic [2*WIDTH-1:0]   w_prod;

`ifdef MULT_SIGNED_EN
    assign w_negA = SGN & A[WIDTH-1];
    assign w_negB = SGN & B[WIDTH-1];
`else
    assign w_negA = 1'b0;
    assign w_negB = 1'b0;
`endif

    // Magnitude of the most-negative value still fits the unsigned operand width.
    assign w_magA = w_negA ? (~A + c_ONE_W) : A;
    assign w_magB = w_negB ? (~B + c_ONE_W) : B;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_sum     = {1'b0, r_accHi} + {1'b0, w_addend};
    // Product as it stands after this cycle's add-and-shift.
    assign w_prodMag = {w_sum, r_mplier[WIDTH-1:1]};
    assign w_prod    = r_neg ? (~w_prodMag + c_ONE_P) : w_prodMag;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= c_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_accHi  <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (START) begin
                        r_state  <= c_RUN;
                        r_mcand  <= w_magA;
                        r_mplier <= w_magB;
                        r_accHi  <= '0;
                        r_count  <= c_CNT_LOAD;
                        r_neg    <= w_negA ^ w_negB;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_accHi  <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_count  <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        r_state <= c_DONE;
                        r_p     <= w_prod;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (r_state == c_RUN);
    assign DONE = (r_state == c_DONE);
    assign P    = r_p;
    assign PLO  = r_p[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_seq_mult32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult32
//  Description : Scoreboard bench for seq_mult32: driver pushes expected
//                products, a negedge monitor pops them on every DONE.
//  Revision    : 1.0
// ============================================================================
module tb_seq_mult32;

    localparam int W = 32;

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic           START = 1'b0;
    logic [W-1:0]   A     = '0;
    logic [W-1:0]   B     = '0;
`ifdef MULT_SIGNED_EN
    logic           SGN   = 1'b0;
`endif
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] P;
    logic [W-1:0]   PLO;

    int nVec  = 0;
    int nErr  = 0;
    int nDone = 0;

    typedef struct {
        logic [63:0] p;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        mEntry;
    logic [63:0] lastP = '0;

    always #5 CLK = ~CLK;

    seq_mult32 #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
`ifdef MULT_SIGNED_EN
        .SGN   (SGN),
`endif
        .BUSY  (BUSY),
        .DONE  (DONE),
        .P     (P),
        .PLO   (PLO)
    );

    // Monitor: product check on DONE, hold check on every other cycle.
    always @(negedge CLK) begin
        if (!RST_N) begin
            lastP = '0;
        end else if (DONE) begin
            nDone++;
            nVec++;
            if (sbQ.size() == 0) begin
                nErr++;
                $display("FAIL unexpected_done: P=%h, required no DONE pulse", P);
            end else begin
                mEntry = sbQ.pop_front();
                if (P !== mEntry.p || PLO !== mEntry.p[31:0]) begin
                    nErr++;
                    $display("FAIL product a=%h b=%h sgn=%b: P=%h PLO=%h, required P=%h PLO=%h",
                             mEntry.a, mEntry.b, mEntry.sgn, P, PLO, mEntry.p, mEntry.p[31:0]);
                end
            end
            lastP = P;
        end else begin
            nVec++;
            if (P !== lastP) begin
                nErr++;
                $display("FAIL p_hold: P=%h, required %h", P, lastP);
            end
        end
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called on the first negedge after acceptance; returns on the DONE negedge.
    task automatic waitDone(input string nm);
        int cyc;
        int busyCyc;
        cyc     = 1;
        busyCyc = 0;
        while (!DONE && cyc < 60) begin
            if (BUSY) busyCyc++;
            @(negedge CLK);
            cyc++;
        end
        nVec++;
        if (!DONE || BUSY || cyc != W + 1 || busyCyc != W) begin
            nErr++;
            $display("FAIL latency_%s: done=%b busy=%b at cycle %0d after %0d busy cycles, required done at cycle %0d after %0d busy cycles",
                     nm, DONE, BUSY, cyc, busyCyc, W + 1, W);
        end
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp);
        @(negedge CLK);
        START = 1'b1;
        A     = a;
        B     = b;
`ifdef MULT_SIGNED_EN
        SGN   = sgn;
`endif
        sbQ.push_back('{p: exp, sgn: sgn, a: a, b: b});
        @(negedge CLK);
        START = 1'b0;
        A     = $urandom;
        B     = $urandom;
        waitDone("op");
    endtask

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] req);
        nVec++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneSnap;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        // Power-on reset
        #1 RST_N = 1'b0;
        #1;
        check1("reset_busy", {63'b0, BUSY}, 64'd0);
        check1("reset_done", {63'b0, DONE}, 64'd0);
        check1("reset_p",    P,             64'd0);
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;

        // Unsigned directed vectors
        runOp(32'd7,         32'd6,         1'b0, 64'd42);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        runOp(32'd0,         32'h1234,      1'b0, 64'd0);
        runOp(32'd1,         32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF);
        runOp(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000);
        runOp(32'hFFFF_FFFD, 32'd5,         1'b0, 64'h0000_0004_FFFF_FFF1);
        runOp(32'd7,         32'd6,         1'b0, 64'd42);

        // Asynchronous reset in the middle of a run
        @(negedge CLK);
        START = 1'b1;
        A     = 32'd5;
        B     = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        check1("midrun_busy_before_reset", {63'b0, BUSY}, 64'd1);
        #2 RST_N = 1'b0;
        #1;
        check1("midrun_reset_busy", {63'b0, BUSY}, 64'd0);
        check1("midrun_reset_done", {63'b0, DONE}, 64'd0);
        check1("midrun_reset_p",    P,             64'd0);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        doneSnap = nDone;
        repeat (45) @(negedge CLK);
        check1("no_done_after_reset", 64'(nDone), 64'(doneSnap));
        check1("idle_after_reset", {63'b0, BUSY}, 64'd0);

        // START re-pulsed during RUN is ignored; START held across DONE chains
        @(negedge CLK);
        START = 1'b1;
        A     = 32'd1000;
        B     = 32'd3000;
        sbQ.push_back('{p: 64'd3_000_000, sgn: 1'b0, a: 32'd1000, b: 32'd3000});
        @(negedge CLK);
        A = 32'd1;
        B = 32'd1;
        waitDone("ignore_start");
        A = 32'h0001_0000;
        B = 32'h0001_0000;
        sbQ.push_back('{p: 64'h0000_0001_0000_0000, sgn: 1'b0, a: 32'h0001_0000, b: 32'h0001_0000});
        @(negedge CLK);
        START = 1'b0;
        check1("back_to_back_busy", {62'b0, BUSY, DONE}, 64'd2);
        waitDone("back_to_back");

`ifdef MULT_SIGNED_EN
        runOp(32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        runOp(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        runOp(32'hFFFF_FFFD, 32'd5,         1'b0, 64'h0000_0004_FFFF_FFF1);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        runOp(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
        runOp(32'd7,         32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
`endif

        // Random operand pairs against the reference product
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) ra = 32'd0;
`ifdef MULT_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            runOp(ra, rb, rs, model(ra, rb, rs));
        end

        repeat (3) @(negedge CLK);
        check1("scoreboard_drained", 64'(sbQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
